wshb_sdram_arbiter: RTL



---
 rtl/wshb_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 13 +
 rtl/wshb_sdram_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_resp_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin chooser: on a tie, the master that did not own last wins.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin Wishbone arbiter sharing the SDRAM slave port between the video
// reader (master 0) and the pixel writer (master 1); no mid-cycle preemption.
module wshb_sdram_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned ADR_W     = 32,
  parameter int unsigned DAT_BYTES = 4,
  parameter int unsigned MAX_HOLD  = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   m0_cyc,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [ADR_W-1:0]       m0_adr,
  input  logic [8*DAT_BYTES-1:0] m0_dat_ms,
  input  logic [DAT_BYTES-1:0]   m0_sel,
  input  logic [2:0]             m0_cti,
  input  logic [1:0]             m0_bte,
  output logic [8*DAT_BYTES-1:0] m0_dat_sm,
  output logic                   m0_ack,
  output logic                   m0_err,
  output logic                   m0_rty,
  input  logic                   m1_cyc,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [ADR_W-1:0]       m1_adr,
  input  logic [8*DAT_BYTES-1:0] m1_dat_ms,
  input  logic [DAT_BYTES-1:0]   m1_sel,
  input  logic [2:0]             m1_cti,
  input  logic [1:0]             m1_bte,
  output logic [8*DAT_BYTES-1:0] m1_dat_sm,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic                   m1_rty,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [ADR_W-1:0]       s_adr,
  output logic [8*DAT_BYTES-1:0] s_dat_ms,
  output logic [DAT_BYTES-1:0]   s_sel,
  output logic [2:0]             s_cti,
  output logic [1:0]             s_bte,
  input  logic [8*DAT_BYTES-1:0] s_dat_sm,
  input  logic                   s_ack,
  input  logic                   s_err,
  input  logic                   s_rty,
  output logic [1:0]             gnt,
  output logic                   starve,
  output logic [CNT_W-1:0]       gnt_cnt0,
  output logic [CNT_W-1:0]       gnt_cnt1
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t        state, state_nxt;
  logic              last;
  logic [1:0]        pick;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_max;
  logic              waiter;
  wb_resp_t          s_resp, m0_resp, m1_resp;

  rr_pick u_rr_pick (
    .req  ({m1_cyc, m0_cyc}),
    .last (last),
    .pick (pick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next owner plus the combinational request/response steering for the current owner.
  always_comb begin
    state_nxt = state;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_ms  = '0;
    s_sel     = '0;
    s_cti     = '0;
    s_bte     = '0;
    m0_resp   = '0;
    m1_resp   = '0;
    unique case (state)
      IDLE: begin
        if (pick[0])      state_nxt = OWN0;
        else if (pick[1]) state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cyc) state_nxt = m1_cyc ? OWN1 : IDLE;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_resp  = s_resp;
      end
      OWN1: begin
        if (!m1_cyc) state_nxt = m0_cyc ? OWN0 : IDLE;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_resp  = s_resp;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_resp    = '{ack: s_ack, err: s_err, rty: s_rty};
  assign m0_ack    = m0_resp.ack;
  assign m0_err    = m0_resp.err;
  assign m0_rty    = m0_resp.rty;
  assign m1_ack    = m1_resp.ack;
  assign m1_err    = m1_resp.err;
  assign m1_rty    = m1_resp.rty;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  assign hold_max = (hold_cnt == HOLD_W'(MAX_HOLD));
  assign waiter   = ((state == OWN0) && m1_cyc) || ((state == OWN1) && m0_cyc);

  // Grant flags, tie-break history, ownership age, starvation and debug counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt      <= 2'b00;
      last     <= 1'b1;
      hold_cnt <= '0;
      starve   <= 1'b0;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      gnt <= {state_nxt == OWN1, state_nxt == OWN0};
      if (state == OWN0 && state_nxt != OWN0) last <= 1'b0;
      if (state == OWN1 && state_nxt != OWN1) last <= 1'b1;
      if (state_nxt == OWN0 && state != OWN0) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (state_nxt == OWN1 && state != OWN1) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      if (state_nxt != state)                hold_cnt <= '0;
      else if (state != IDLE && !hold_max)   hold_cnt <= hold_cnt + HOLD_W'(1);
      if (hold_max && waiter) starve <= 1'b1;
    end
  end

endmodule
